dpu_ctrl: RTL and testbench

Memory-mapped controller for the dot-product unit (DPU), sitting behind the MMIO splitter on the `dp_*` port (byte addresses 0, 4 and 8).
- It accepts CPU loads and stores through a req/ack handshake and buffers operand pairs in a small FIFO.
- It sequences a pipelined signed multiply-accumulate over a programmed vector length, then exposes busy/done status and the 32-bit result.

---
 rtl/dpu_pkg.sv | 26 ++
 rtl/dpu_ctrl_if.sv | 20 ++
 rtl/dpu_opfifo.sv | 49 ++++
 rtl/dpu_ctrl.sv | 154 +++++++++++++++
 tb/tb_dpu_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpu_pkg.sv
// Shared definitions for the dot-product unit controller: register map, CTRL/STATUS
// bit positions, FSM state encoding and the operand FIFO entry layout.
package dpu_pkg;

  // Register select, decoded from byte address bits [3:2].
  localparam logic [1:0] DPU_CTRL = 2'd0;
  localparam logic [1:0] DPU_OPND = 2'd1;
  localparam logic [1:0] DPU_RES  = 2'd2;

  localparam int unsigned CTRL_START_BIT = 31;
  localparam int unsigned CTRL_CLR_BIT   = 30;
  localparam int unsigned STAT_BUSY_BIT  = 31;
  localparam int unsigned STAT_DONE_BIT  = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dpu_state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } dpu_opnd_t;

endpackage

// File: rtl/dpu_ctrl_if.sv
// MMIO request/ack port between the splitter (master) and the DPU controller (slave).
interface dpu_ctrl_if;
  logic        dp_req;
  logic        dp_lw;
  logic [31:0] dp_addr;
  logic [31:0] dp_write_data;
  logic        dp_ack;
  logic [31:0] dp_read_data;
  logic        dp_busy;

  modport master (
    output dp_req, dp_lw, dp_addr, dp_write_data,
    input  dp_ack, dp_read_data, dp_busy
  );

  modport slave (
    input  dp_req, dp_lw, dp_addr, dp_write_data,
    output dp_ack, dp_read_data, dp_busy
  );
endinterface

// File: rtl/dpu_opfifo.sv
// Synchronous operand FIFO; push when full and pop when empty are ignored.
module dpu_opfifo
  import dpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dpu_opnd_t              wdata,
  input  logic                   pop,
  output dpu_opnd_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  dpu_opnd_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dpu_ctrl.sv
// MMIO controller for the dot-product unit: register decode, operand FIFO, sequencing FSM
// and a two-stage signed MAC. Define DPU_SATURATE_EN to saturate the accumulate.
module dpu_ctrl
  import dpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input logic       clk,
  input logic       rst,
  dpu_ctrl_if.slave dp
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  function automatic logic [31:0] mac_add(input logic [31:0] acc, input logic [31:0] prod);
    logic [31:0] sum;
    sum = acc + prod;
`ifdef DPU_SATURATE_EN
    if ((acc[31] == prod[31]) && (sum[31] != acc[31])) begin
      sum = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    return sum;
  endfunction

  dpu_state_t     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic           done_q, done_d;
  logic [31:0]    acc_q, acc_d;
  logic [31:0]    prod_q, prod_d;
  logic           prod_vld_q;
  logic           ack_q;
  logic [31:0]    rdata_q, rdata_d;

  logic [1:0]     reg_sel;
  logic           opnd_st, accept, st_acc, busy;
  logic           start_req, clr_req, res_clr_req;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  dpu_opnd_t      fifo_rdata;
  logic           unused_addr;

  assign reg_sel     = dp.dp_addr[3:2];
  assign unused_addr = ^{dp.dp_addr[31:4], dp.dp_addr[1:0]};
  assign opnd_st     = !dp.dp_lw && (reg_sel == DPU_OPND);
  // Full is judged on current occupancy, so a same-cycle pop does not let a push through.
  assign accept      = dp.dp_req && !ack_q && !(opnd_st && fifo_full);
  assign st_acc      = accept && !dp.dp_lw;
  assign fifo_push   = st_acc && (reg_sel == DPU_OPND);
  assign start_req   = st_acc && (reg_sel == DPU_CTRL) && dp.dp_write_data[CTRL_START_BIT];
  assign clr_req     = st_acc && (reg_sel == DPU_CTRL) && dp.dp_write_data[CTRL_CLR_BIT];
  assign res_clr_req = st_acc && (reg_sel == DPU_RES);
  assign busy        = (state_q != IDLE);

  dpu_opfifo #(
    .DEPTH (DEPTH)
  ) u_opfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (dp.dp_write_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign prod_d = {{16{fifo_rdata.a[15]}}, fifo_rdata.a} * {{16{fifo_rdata.b[15]}}, fifo_rdata.b};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    done_d   = done_q;
    acc_d    = acc_q;
    fifo_pop = 1'b0;
    if (prod_vld_q) acc_d = mac_add(acc_q, prod_q);
    if (clr_req)    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (res_clr_req) acc_d = '0;
        if (start_req) begin
          acc_d = '0;
          len_d = dp.dp_write_data[LEN_W-1:0];
          if (dp.dp_write_data[LEN_W-1:0] == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = '0;
            done_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          count_d  = count_q + LEN_W'(1);
          if (count_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last product sits in stage 1 and retires into acc this cycle.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    unique case (reg_sel)
      DPU_CTRL: begin
        rdata_d[STAT_BUSY_BIT] = busy;
        rdata_d[STAT_DONE_BIT] = done_q;
        rdata_d[LEN_W-1:0]     = count_q;
      end
      DPU_OPND: rdata_d = 32'(fifo_count);
      DPU_RES:  rdata_d = acc_q;
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= fifo_pop;
      ack_q      <= accept;
      rdata_q    <= (accept && dp.dp_lw) ? rdata_d : '0;
    end
  end

  assign dp.dp_ack       = ack_q;
  assign dp.dp_read_data = rdata_q;
  assign dp.dp_busy      = busy;

endmodule

// File: tb/tb_dpu_ctrl.sv
// Scoreboard bench for dpu_ctrl: stimulus queues expected load data, a negedge monitor
// pops and compares on every ack.
module tb_dpu_ctrl;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_OPND = 32'h4;
  localparam logic [31:0] A_RES  = 32'h8;
  localparam logic [31:0] A_NONE = 32'hC;

  typedef struct {
    logic        chk;
    logic [31:0] mask;
    logic [31:0] exp;
    string       name;
  } sb_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;
  sb_t  sb_q[$];

  dpu_ctrl_if dp_if ();

  dpu_ctrl #(
    .DEPTH (8),
    .LEN_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dp_if.dp_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack (rdata 0x%08h), expected none",
                 dp_if.dp_read_data);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.chk) check(e.name, dp_if.dp_read_data & e.mask, e.exp);
      end
    end else if (cyc > 0) begin
      check("rdata_zero_without_ack", dp_if.dp_read_data, 32'h0);
    end
  end

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dp_if.dp_ack !== 1'b1 && n < 200);
    if (dp_if.dp_ack !== 1'b1) begin
      n_checks++;
      $display("FAIL %s_timeout: got no ack in 200 cycles, expected ack", name);
      void'(sb_q.pop_back());
    end
    dp_if.dp_req = 1'b0;
  endtask

  task automatic xact(input logic lw, input logic [31:0] addr, input logic [31:0] wd,
                      input logic chk, input logic [31:0] mask, input logic [31:0] exp,
                      input string name);
    sb_q.push_back('{chk, mask, exp, name});
    dp_if.dp_req        = 1'b1;
    dp_if.dp_lw         = lw;
    dp_if.dp_addr       = addr;
    dp_if.dp_write_data = wd;
    wait_ack(name);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    xact(1'b0, addr, wd, 1'b0, 32'h0, 32'h0, "store");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    xact(1'b1, addr, 32'h0, 1'b1, 32'hFFFF_FFFF, exp, name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dp_if.dp_busy !== 1'b0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (dp_if.dp_busy !== 1'b0) begin
      n_checks++;
      $display("FAIL %s_timeout: busy stuck at 1, expected 0", name);
    end
  endtask

  function automatic logic [31:0] prod(input logic [31:0] w);
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] p;
    a = w[31:16];
    b = w[15:0];
    p = a * b;
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill[9];
    logic [31:0] model;
    logic [31:0] sat_exp;
    int          acks;
    int          t0;

    fill = '{32'h0001_0002, 32'hFFFF_0003, 32'h0010_0010, 32'h8000_0002, 32'h0005_FFFB,
             32'h1234_0001, 32'hFFFE_FFFE, 32'h0003_0007, 32'h7FFF_8000};
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst      = 1'b1;
    dp_if.dp_req        = 1'b0;
    dp_if.dp_lw         = 1'b0;
    dp_if.dp_addr       = 32'h0;
    dp_if.dp_write_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(dp_if.dp_ack), 32'h0);
    check("reset_busy", 32'(dp_if.dp_busy), 32'h0);
    check("reset_rdata", dp_if.dp_read_data, 32'h0);
    rst = 1'b0;
    rd(A_CTRL, 32'h0, "reset_status");
    rd(A_OPND, 32'h0, "reset_occupancy");
    rd(A_RES, 32'h0, "reset_result");

    // Basic three-element dot product.
    wr(A_CTRL, 32'h8000_0003);
    check("busy_after_start", 32'(dp_if.dp_busy), 32'h1);
    wr(A_OPND, 32'h0002_0003);
    wr(A_OPND, 32'hFFFC_0005);
    wr(A_OPND, 32'h0007_FFFF);
    wait_idle("basic");
    rd(A_RES, 32'hFFFF_FFEB, "basic_result");
    rd(A_CTRL, 32'h4000_0003, "basic_status");

    // Fill the FIFO, then a ninth push is withheld until the run frees an entry.
    model = 32'h0;
    for (int i = 0; i < 8; i++) wr(A_OPND, fill[i]);
    for (int i = 0; i < 9; i++) model = model + prod(fill[i]);
    rd(A_OPND, 32'h8, "full_occupancy");
    acks = 0;
    dp_if.dp_req        = 1'b1;
    dp_if.dp_lw         = 1'b0;
    dp_if.dp_addr       = A_OPND;
    dp_if.dp_write_data = fill[8];
    repeat (10) begin
      @(posedge clk);
      #1;
      if (dp_if.dp_ack === 1'b1) acks++;
    end
    dp_if.dp_req = 1'b0;
    check("full_push_withheld", 32'(acks), 32'h0);
    wr(A_CTRL, 32'h8000_0009);
    t0 = cyc;
    wr(A_OPND, fill[8]);
    check("ninth_ack_latency", 32'(cyc - t0), 32'h2);
    wait_idle("fill");
    rd(A_RES, model, "fill_result");
    rd(A_CTRL, 32'h4000_0009, "fill_status");

    // Overflow behaviour of the accumulate.
`ifdef DPU_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'hBFFD_0003;
`endif
    wr(A_CTRL, 32'h8000_0003);
    repeat (3) wr(A_OPND, 32'h7FFF_7FFF);
    wait_idle("overflow");
    rd(A_RES, sat_exp, "overflow_result");

    // Starved run, ignored mid-run start and result clear, done timing.
    wr(A_CTRL, 32'h8000_0004);
    wr(A_OPND, 32'h0003_0004);
    wr(A_OPND, 32'hFFFE_0005);
    repeat (20) @(posedge clk);
    #1;
    check("starved_busy", 32'(dp_if.dp_busy), 32'h1);
    rd(A_CTRL, 32'h8000_0002, "starved_status");
    wr(A_CTRL, 32'h8000_0007);
    wr(A_RES, 32'h0);
    rd(A_CTRL, 32'h8000_0002, "midrun_start_ignored");
    wr(A_OPND, 32'h0100_0100);
    wr(A_OPND, 32'hFFFF_FFFF);
    check("busy_at_last_pop", 32'(dp_if.dp_busy), 32'h1);
    @(posedge clk);
    #1;
    check("busy_at_accumulate", 32'(dp_if.dp_busy), 32'h1);
    @(posedge clk);
    #1;
    check("busy_clear_two_after_pop", 32'(dp_if.dp_busy), 32'h0);
    rd(A_CTRL, 32'h4000_0004, "starved_done_status");

    // Loads have no side effects; clear-done, result clear and zero-length start.
    repeat (3) rd(A_RES, 32'h0001_0003, "repeat_result");
    rd(A_CTRL, 32'h4000_0004, "done_kept_after_loads");
    wr(A_CTRL, 32'h4000_0000);
    rd(A_CTRL, 32'h0000_0004, "clear_done");
    wr(A_RES, 32'h0);
    rd(A_RES, 32'h0, "idle_result_clear");
    wr(A_NONE, 32'hFFFF_FFFF);
    rd(A_NONE, 32'h0, "unmapped_read");
    rd(A_OPND, 32'h0, "unmapped_write_no_push");
    wr(A_CTRL, 32'h8000_0001);
    wr(A_OPND, 32'h0003_0004);
    wait_idle("single");
    rd(A_RES, 32'd12, "single_result");
    wr(A_CTRL, 32'h8000_0000);
    xact(1'b1, A_CTRL, 32'h0, 1'b1, 32'hC000_0000, 32'h4000_0000, "zero_len_done");
    rd(A_RES, 32'h0, "zero_len_result");

    // Reset in the middle of a run with a request held across it.
    for (int i = 0; i < 5; i++) wr(A_OPND, fill[i]);
    wr(A_CTRL, 32'h8000_0008);
    rst                 = 1'b1;
    dp_if.dp_req        = 1'b1;
    dp_if.dp_lw         = 1'b1;
    dp_if.dp_addr       = A_OPND;
    @(posedge clk);
    #1;
    check("midrun_rst_busy", 32'(dp_if.dp_busy), 32'h0);
    check("midrun_rst_ack", 32'(dp_if.dp_ack), 32'h0);
    check("midrun_rst_rdata", dp_if.dp_read_data, 32'h0);
    @(posedge clk);
    #1;
    check("held_req_no_ack_in_rst", 32'(dp_if.dp_ack), 32'h0);
    rst = 1'b0;
    sb_q.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0, "occupancy_after_rst"});
    wait_ack("occupancy_after_rst");
    rd(A_CTRL, 32'h0, "status_after_rst");
    rd(A_RES, 32'h0, "result_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
